// File: rtl/delay_probe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// delay_probe_ctrl_pkg
//   Shared definitions for the delay-probe launch/capture controller:
//   FSM state encoding, the default discharge length and a small helper.
//   No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package delay_probe_ctrl_pkg;

    // Default number of discharge cycles per trial (launch held low).
    localparam int PRE_CYC_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        LAUNCH    = 3'd2,
        CAPTURE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/delay_probe_ctrl_sat.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear, count enable and saturation at
//   all-ones. Clear has priority over enable.
//
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear
//   en     in   increment enable (no effect once saturated)
//   count  out  current count, W bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/delay_probe_ctrl.sv
// -----------------------------------------------------------------------------
// delay_probe_ctrl
//   Launch/capture controller for a delay-sensor path. Each trial discharges
//   the path (launch low for PRE_CYC cycles), launches a rising edge for D
//   cycles, samples the path output on the edge ending the last launch
//   cycle, and counts the trials whose sample was 1.
//
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle run request (ignored while busy)
//   num_trials     in   trial count N, latched at start
//   capture_delay  in   launch cycles before capture, latched at start (0 -> 1)
//   path_in        in   output of the delay path under test (sampled raw)
//   launch         out  registered drive of the delay path input
//   busy           out  high in every state except IDLE
//   done           out  one-cycle pulse in DONE
//   hit_count      out  trials whose captured sample was 1 (saturating)
//   cycle_count    out  PRECHARGE/LAUNCH/CAPTURE cycles of the run (saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module delay_probe_ctrl
    import delay_probe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TRIAL_W = 16,
    parameter int WAIT_W  = 8,
    parameter int PRE_CYC = PRE_CYC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TRIAL_W-1:0] num_trials,
    input  logic [WAIT_W-1:0]  capture_delay,
    input  logic               path_in,
    output logic               launch,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   cycle_count
);

    // The phase timer must hold both PRE_CYC-1 and D-1.
    localparam int TMR_W = max_int(WAIT_W, $clog2(PRE_CYC + 1));
    localparam logic [TMR_W-1:0] PRE_LOAD = TMR_W'(PRE_CYC - 1);

    state_t             state, state_nxt;
    logic [TRIAL_W-1:0] trials_left, trials_nxt;
    logic [WAIT_W-1:0]  delay_q, delay_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               sample_q, sample_nxt;
    logic               launch_nxt;
    logic               cnt_clr;
    logic               cycle_en;
    logic               hit_en;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trials_left <= '0;
            delay_q     <= '0;
            timer       <= '0;
            sample_q    <= 1'b0;
            launch      <= 1'b0;
        end else begin
            state       <= state_nxt;
            trials_left <= trials_nxt;
            delay_q     <= delay_nxt;
            timer       <= timer_nxt;
            sample_q    <= sample_nxt;
            launch      <= launch_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        trials_nxt = trials_left;
        delay_nxt  = delay_q;
        timer_nxt  = timer;
        sample_nxt = sample_q;
        cnt_clr    = 1'b0;
        cycle_en   = 1'b0;
        hit_en     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    if (num_trials != '0) begin
                        trials_nxt = num_trials;
                        // A zero capture delay still needs one launch cycle.
                        delay_nxt  = (capture_delay == '0) ? WAIT_W'(1) : capture_delay;
                        timer_nxt  = PRE_LOAD;
                        state_nxt  = PRECHARGE;
                    end else begin
                        state_nxt  = DONE;
                    end
                end
            end

            PRECHARGE: begin
                cycle_en = 1'b1;
                if (timer == '0) begin
                    timer_nxt = TMR_W'(delay_q) - TMR_W'(1);
                    state_nxt = LAUNCH;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            LAUNCH: begin
                cycle_en = 1'b1;
                if (timer == '0) begin
                    // Raw single-flop sample: metastability is part of the
                    // measurement, so there is deliberately no synchronizer.
                    sample_nxt = path_in;
                    state_nxt  = CAPTURE;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            CAPTURE: begin
                cycle_en   = 1'b1;
                hit_en     = sample_q;
                trials_nxt = trials_left - TRIAL_W'(1);
                if (trials_left == TRIAL_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    timer_nxt = PRE_LOAD;
                    state_nxt = PRECHARGE;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // launch is registered from the next state so it is a clean flop output
    // that is high exactly during LAUNCH cycles.
    assign launch_nxt = (state_nxt == LAUNCH);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Result counters
    // ------------------------------------------------------------------
    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (hit_en),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cycle_en),
        .count (cycle_count)
    );

endmodule
